// File: rtl/fifo_pkg.sv
// Shared defaults and the occupancy status enum for the parameterised FIFO.
package fifo_pkg;

    localparam int DEFAULT_FIFO_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        FIFO_EMPTY        = 3'd0,
        FIFO_ALMOST_EMPTY = 3'd1,
        FIFO_MID          = 3'd2,
        FIFO_ALMOST_FULL  = 3'd3,
        FIFO_FULL         = 3'd4
    } fifo_state_e;

    // Empty and full take priority over the threshold states.
    function automatic fifo_state_e fifo_status(input int unsigned cnt, input int unsigned depth,
                                                input int unsigned ae, input int unsigned af);
        if (cnt == 0)          return FIFO_EMPTY;
        else if (cnt == depth) return FIFO_FULL;
        else if (cnt <= ae)    return FIFO_ALMOST_EMPTY;
        else if (cnt >= af)    return FIFO_ALMOST_FULL;
        else                   return FIFO_MID;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            w_en,
    input  logic                            r_en,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_empty,
    output logic                            almost_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

    generate
        if (!(FIFO_WIDTH >= 1 && FIFO_DEPTH >= 2 && AE_THRESH >= 0 &&
              AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH)) begin : g_bad_params
            $error("sync_fifo_param: need WIDTH>=1, DEPTH>=2, 0<=AE_THRESH<AF_THRESH<=DEPTH");
        end
    endgenerate

    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic [FIFO_WIDTH-1:0] ram_rdata;
    logic                  rd_acc;
    logic                  wr_acc;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Flags decode only registered state; no path from w_en/r_en.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_C);
    assign almost_empty = (count_reg <= AE_C);
    assign almost_full  = (count_reg >= AF_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A read on a full FIFO frees the slot the same-cycle write lands in.
    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (rd_acc) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (w_en && full && !rd_acc) begin
                overflow_reg <= 1'b1;
            end
            if (r_en && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .wdata (data_in),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : ram_rdata;
`else
    logic [FIFO_WIDTH-1:0] data_out_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_reg <= '0;
        end else if (rd_acc) begin
            data_out_reg <= ram_rdata;
        end
    end

    assign data_out = data_out_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (W=8, D=6, AF=5, AE=1) against a queue model.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 5;
    localparam int AE    = 1;
`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         w_en = 1'b0;
    logic         r_en = 1'b0;
    logic [W-1:0] data_out;
    logic         empty, full, almost_empty, almost_full;
    logic [2:0]   count;
    logic         overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q [$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;
    logic [W-1:0] m_dout_reg = '0;

    typedef struct {
        bit           w;
        bit           r;
        logic [W-1:0] d;
        int           cnt;
        bit           full;
        bit           empty;
        bit           af;
        bit           ae;
        logic [W-1:0] dout;
    } vec_t;

    vec_t tbl [12];

    sync_fifo_param #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_dout();
        if (FWFT) return (q.size() > 0) ? q[0] : '0;
        return m_dout_reg;
    endfunction

    task automatic model_edge(input bit w, input bit r, input logic [W-1:0] d);
        int  n    = q.size();
        bit  racc = r && (n > 0);
        bit  wacc = w && ((n < DEPTH) || racc);
        if (w && n == DEPTH && !racc) m_ovf = 1'b1;
        if (r && n == 0) m_unf = 1'b1;
        if (racc) m_dout_reg = q.pop_front();
        if (wacc) q.push_back(d);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_dout_reg = '0;
    endtask

    task automatic check_model();
        int n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("data_out", 32'(data_out), 32'(exp_dout()));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input bit w, input bit r, input logic [W-1:0] d);
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        model_edge(w, r, d);
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        check_model();
        $display("txn w=%0d r=%0d din=%h cnt=%0d dout=%h ovf=%0d unf=%0d st=%s",
                 w, r, d, count, data_out, overflow, underflow,
                 fifo_status(q.size(), DEPTH, AE, AF).name());
    endtask

    task automatic read_word(output logic [W-1:0] v);
        if (FWFT) v = data_out;
        step(1'b0, 1'b1, '0);
        if (!FWFT) v = data_out;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
        chk({tag, "_af"}, 32'(almost_full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_unf"}, 32'(underflow), 32'd0);
        chk({tag, "_dout"}, 32'(data_out), 32'd0);
    endtask

    // Reset asserted between edges; outputs must clear before the next rising edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        $display("txn reset %s", tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] nxt;
        int           wprob;

        tbl[0]  = '{1, 0, 8'h11, 1, 0, 0, 0, 1, FWFT ? 8'h11 : 8'h00};
        tbl[1]  = '{1, 0, 8'h22, 2, 0, 0, 0, 0, FWFT ? 8'h11 : 8'h00};
        tbl[2]  = '{1, 0, 8'h33, 3, 0, 0, 0, 0, FWFT ? 8'h11 : 8'h00};
        tbl[3]  = '{1, 0, 8'h44, 4, 0, 0, 0, 0, FWFT ? 8'h11 : 8'h00};
        tbl[4]  = '{1, 0, 8'h55, 5, 0, 0, 1, 0, FWFT ? 8'h11 : 8'h00};
        tbl[5]  = '{1, 0, 8'h66, 6, 1, 0, 1, 0, FWFT ? 8'h11 : 8'h00};
        tbl[6]  = '{0, 1, 8'h00, 5, 0, 0, 1, 0, FWFT ? 8'h22 : 8'h11};
        tbl[7]  = '{0, 1, 8'h00, 4, 0, 0, 0, 0, FWFT ? 8'h33 : 8'h22};
        tbl[8]  = '{0, 1, 8'h00, 3, 0, 0, 0, 0, FWFT ? 8'h44 : 8'h33};
        tbl[9]  = '{0, 1, 8'h00, 2, 0, 0, 0, 0, FWFT ? 8'h55 : 8'h44};
        tbl[10] = '{0, 1, 8'h00, 1, 0, 0, 0, 1, FWFT ? 8'h66 : 8'h55};
        tbl[11] = '{0, 1, 8'h00, 0, 0, 1, 0, 1, FWFT ? 8'h00 : 8'h66};

        #1;
        rst = 1'b1;
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full then drain, checked against hand-computed vectors.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_af", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d_ae", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
        end

        // Simultaneous write and read while full.
        for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b0, 8'(k * 17));
        step(1'b1, 1'b1, 8'h77);
        chk("simul_full_count", 32'(count), 32'd6);
        chk("simul_full_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            read_word(v);
            chk($sformatf("simul_full_rd%0d", k), 32'(v), (k == 5) ? 32'h77 : 32'((k + 2) * 17));
        end

        // Read on empty with same-cycle write: read rejected, write accepted.
        step(1'b1, 1'b1, 8'hA5);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
        chk("empty_rw_count", 32'(count), 32'd1);
        read_word(v);
        chk("empty_rw_data", 32'(v), 32'hA5);

        // Streaming 20 words through at occupancy 1, wrapping the pointers.
        nxt = 8'h40;
        step(1'b1, 1'b0, nxt);
        for (int k = 1; k < 20; k++) begin
            nxt = nxt + 8'd1;
            step(1'b1, 1'b1, nxt);
            chk($sformatf("stream_ae%0d", k), 32'(almost_empty), 32'd1);
            if (!FWFT) chk($sformatf("stream_dout%0d", k), 32'(data_out), 32'(nxt - 8'd1));
        end
        read_word(v);
        chk("stream_last", 32'(v), 32'(nxt));

        // Overflow: write on full without a read is dropped and flagged.
        for (int k = 1; k <= DEPTH; k++) step(1'b1, 1'b0, 8'(k));
        step(1'b1, 1'b0, 8'h99);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd6);
        for (int k = 1; k <= DEPTH; k++) begin
            read_word(v);
            chk($sformatf("ovf_rd%0d", k), 32'(v), 32'(k));
        end

        // Reset mid-operation discards contents and clears sticky flags.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'(8'hC0 + k));
        do_reset("midrst");
        step(1'b0, 1'b1, '0);
        chk("post_rst_unf", 32'(underflow), 32'd1);
        chk("post_rst_count", 32'(count), 32'd0);

        // Randomised traffic in phases of varying write bias.
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            wprob = (i < 100) ? 70 : (i < 200) ? 30 : (i < 300) ? 50 : 85;
            if (i == 250) do_reset("rnd_mid");
            step($urandom_range(0, 99) < wprob, $urandom_range(0, 99) < (100 - wprob),
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
